// File: rtl/rename_stage_if.sv
// rtl/rename_stage_if.sv - bundle, free-list, commit and dispatch signals of the rename stage
//
// Purpose: groups every non-clock/reset signal of rename_stage.
//   slave  : the rename stage itself
//   master : the surrounding pipeline (decode, free_list, ROB, dispatch)
// Signal summary (per-slot fields are [1:0], slot k at index k):
//   in_valid/in_ready, in_inst_valid, in_rs1/in_rs2/in_rd, in_rd_we : decoded bundle
//   alloc_en -> / alloc_phys, alloc_valid <-                         : free_list ports
//   commit_en, commit_rd, commit_pd, flush                           : ROB retire / recovery
//   out_valid/out_ready, out_inst_valid, out_pd_valid,
//   out_ps1, out_ps2, out_pd, out_pd_old                             : renamed bundle
interface rename_stage_if #(
  parameter int PW = 6,
  parameter int AW = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_inst_valid;
  logic [1:0]         in_rd_we;
  logic [1:0][AW-1:0] in_rs1;
  logic [1:0][AW-1:0] in_rs2;
  logic [1:0][AW-1:0] in_rd;

  logic [1:0]         alloc_en;
  logic [1:0][PW-1:0] alloc_phys;
  logic [1:0]         alloc_valid;

  logic [1:0]         commit_en;
  logic [1:0][AW-1:0] commit_rd;
  logic [1:0][PW-1:0] commit_pd;
  logic               flush;

  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_inst_valid;
  logic [1:0]         out_pd_valid;
  logic [1:0][PW-1:0] out_ps1;
  logic [1:0][PW-1:0] out_ps2;
  logic [1:0][PW-1:0] out_pd;
  logic [1:0][PW-1:0] out_pd_old;

  modport master (
    output in_valid, in_inst_valid, in_rd_we, in_rs1, in_rs2, in_rd,
    output alloc_phys, alloc_valid,
    output commit_en, commit_rd, commit_pd, flush,
    output out_ready,
    input  in_ready, alloc_en,
    input  out_valid, out_inst_valid, out_pd_valid, out_ps1, out_ps2, out_pd, out_pd_old
  );

  modport slave (
    input  in_valid, in_inst_valid, in_rd_we, in_rs1, in_rs2, in_rd,
    input  alloc_phys, alloc_valid,
    input  commit_en, commit_rd, commit_pd, flush,
    input  out_ready,
    output in_ready, alloc_en,
    output out_valid, out_inst_valid, out_pd_valid, out_ps1, out_ps2, out_pd, out_pd_old
  );
endinterface

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - two-wide register rename stage in front of free_list
//
// Purpose: accepts a decoded two-slot bundle, obtains destination physical
// registers from free_list, maps sources through the speculative RAT and emits
// the renamed bundle with each destination's previous mapping. A committed RAT
// tracks ROB retirement and restores the speculative RAT on flush.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : rename_stage_if.slave (bundle in, free_list, commit/flush, bundle out)
module rename_stage #(
  parameter int PHYS_REGS = 48,
  parameter int ARCH_REGS = 32
) (
  input logic           clk,
  input logic           reset,
  rename_stage_if.slave bus
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int AW = $clog2(ARCH_REGS);
  localparam logic [AW-1:0] XZR = AW'(ARCH_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_e;
  state_e state_q, state_d;

  // Latched bundle
  logic [1:0]         b_inst_q, b_inst_d;
  logic [1:0]         b_need_q, b_need_d;
  logic [1:0][AW-1:0] b_rs1_q, b_rs1_d;
  logic [1:0][AW-1:0] b_rs2_q, b_rs2_d;
  logic [1:0][AW-1:0] b_rd_q, b_rd_d;

  // Free-list bookkeeping: ports requested last cycle and registers held per port
  logic [1:0]         req_q;
  logic [1:0]         hold_valid_q, hold_valid_d;
  logic [1:0][PW-1:0] hold_phys_q, hold_phys_d;

  logic [PW-1:0] spec_q [ARCH_REGS];
  logic [PW-1:0] spec_d [ARCH_REGS];
  logic [PW-1:0] commit_q [ARCH_REGS];
  logic [PW-1:0] commit_d [ARCH_REGS];

  // Registered outputs
  logic [1:0]         o_inst_q, o_inst_d;
  logic [1:0]         o_pdv_q, o_pdv_d;
  logic [1:0][PW-1:0] o_ps1_q, o_ps1_d;
  logic [1:0][PW-1:0] o_ps2_q, o_ps2_d;
  logic [1:0][PW-1:0] o_pd_q, o_pd_d;
  logic [1:0][PW-1:0] o_pdo_q, o_pdo_d;

  logic               in_ready;
  logic               accept;
  logic [1:0]         alloc_en;
  logic [1:0]         need_in;
  logic [1:0]         grant;
  logic [1:0]         hv_eff;
  logic [1:0]         missing;
  logic [1:0][PW-1:0] hp_eff;
  logic [1:0][PW-1:0] ren_ps1, ren_ps2, ren_pd, ren_pdo;

  function automatic logic [PW-1:0] map_src(input logic [AW-1:0] a, input logic [PW-1:0] m);
    return (a == XZR) ? PW'(XZR) : m;
  endfunction

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  assign need_in = bus.in_inst_valid & bus.in_rd_we & {bus.in_rd[1] != XZR, bus.in_rd[0] != XZR};

  // A grant is always captured, even across flush, so no physical register leaks.
  assign grant     = req_q & bus.alloc_valid;
  assign hv_eff    = hold_valid_q | grant;
  assign hp_eff[0] = grant[0] ? bus.alloc_phys[0] : hold_phys_q[0];
  assign hp_eff[1] = grant[1] ? bus.alloc_phys[1] : hold_phys_q[1];
  assign missing   = b_need_q & ~hv_eff;

  // Committed RAT next state; port 1 is applied last so it wins on equal rd.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) commit_d[i] = commit_q[i];
    if (bus.commit_en[0] && bus.commit_rd[0] != XZR) commit_d[bus.commit_rd[0]] = bus.commit_pd[0];
    if (bus.commit_en[1] && bus.commit_rd[1] != XZR) commit_d[bus.commit_rd[1]] = bus.commit_pd[1];
  end

  // Rename of the latched bundle; slot 1 bypasses slot 0's new destination.
  always_comb begin
    ren_pd[0]  = b_need_q[0] ? hp_eff[0] : '0;
    ren_pd[1]  = b_need_q[1] ? hp_eff[1] : '0;
    ren_ps1[0] = b_inst_q[0] ? map_src(b_rs1_q[0], spec_q[b_rs1_q[0]]) : '0;
    ren_ps2[0] = b_inst_q[0] ? map_src(b_rs2_q[0], spec_q[b_rs2_q[0]]) : '0;
    ren_ps1[1] = '0;
    ren_ps2[1] = '0;
    if (b_inst_q[1]) begin
      ren_ps1[1] = (b_need_q[0] && b_rs1_q[1] == b_rd_q[0]) ? ren_pd[0]
                 : map_src(b_rs1_q[1], spec_q[b_rs1_q[1]]);
      ren_ps2[1] = (b_need_q[0] && b_rs2_q[1] == b_rd_q[0]) ? ren_pd[0]
                 : map_src(b_rs2_q[1], spec_q[b_rs2_q[1]]);
    end
    ren_pdo[0] = b_need_q[0] ? spec_q[b_rd_q[0]] : '0;
    ren_pdo[1] = '0;
    if (b_need_q[1]) begin
      ren_pdo[1] = (b_need_q[0] && b_rd_q[1] == b_rd_q[0]) ? ren_pd[0] : spec_q[b_rd_q[1]];
    end
  end

  always_comb begin
    state_d      = state_q;
    alloc_en     = '0;
    b_inst_d     = b_inst_q;
    b_need_d     = b_need_q;
    b_rs1_d      = b_rs1_q;
    b_rs2_d      = b_rs2_q;
    b_rd_d       = b_rd_q;
    hold_valid_d = hv_eff;
    hold_phys_d  = hp_eff;
    o_inst_d     = o_inst_q;
    o_pdv_d      = o_pdv_q;
    o_ps1_d      = o_ps1_q;
    o_ps2_d      = o_ps2_q;
    o_pd_d       = o_pd_q;
    o_pdo_d      = o_pdo_q;
    for (int i = 0; i < ARCH_REGS; i++) spec_d[i] = spec_q[i];

    // Accept is possible in IDLE and in the OUT drain cycle; ports already
    // holding a register are not requested again.
    if (accept) begin
      b_inst_d = bus.in_inst_valid;
      b_need_d = need_in;
      b_rs1_d  = bus.in_rs1;
      b_rs2_d  = bus.in_rs2;
      b_rd_d   = bus.in_rd;
      alloc_en = need_in & ~hv_eff;
    end

    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (|missing) begin
          alloc_en = missing;
        end else begin
          o_inst_d     = b_inst_q;
          o_pdv_d      = b_need_q;
          o_ps1_d      = ren_ps1;
          o_ps2_d      = ren_ps2;
          o_pd_d       = ren_pd;
          o_pdo_d      = ren_pdo;
          hold_valid_d = hv_eff & ~b_need_q;
          if (b_need_q[0]) spec_d[b_rd_q[0]] = ren_pd[0];
          if (b_need_q[1]) spec_d[b_rd_q[1]] = ren_pd[1];
          state_d = S_OUT;
        end
      end
      S_OUT: if (bus.out_ready) state_d = accept ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything above except grant capture.
    if (bus.flush) begin
      state_d      = S_IDLE;
      alloc_en     = '0;
      b_inst_d     = '0;
      b_need_d     = '0;
      hold_valid_d = hv_eff;
      o_inst_d     = o_inst_q;
      o_pdv_d      = o_pdv_q;
      o_ps1_d      = o_ps1_q;
      o_ps2_d      = o_ps2_q;
      o_pd_d       = o_pd_q;
      o_pdo_d      = o_pdo_q;
      for (int i = 0; i < ARCH_REGS; i++) spec_d[i] = commit_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      b_inst_q     <= '0;
      b_need_q     <= '0;
      b_rs1_q      <= '0;
      b_rs2_q      <= '0;
      b_rd_q       <= '0;
      req_q        <= '0;
      hold_valid_q <= '0;
      hold_phys_q  <= '0;
      o_inst_q     <= '0;
      o_pdv_q      <= '0;
      o_ps1_q      <= '0;
      o_ps2_q      <= '0;
      o_pd_q       <= '0;
      o_pdo_q      <= '0;
    end else begin
      state_q      <= state_d;
      b_inst_q     <= b_inst_d;
      b_need_q     <= b_need_d;
      b_rs1_q      <= b_rs1_d;
      b_rs2_q      <= b_rs2_d;
      b_rd_q       <= b_rd_d;
      req_q        <= alloc_en;
      hold_valid_q <= hold_valid_d;
      hold_phys_q  <= hold_phys_d;
      o_inst_q     <= o_inst_d;
      o_pdv_q      <= o_pdv_d;
      o_ps1_q      <= o_ps1_d;
      o_ps2_q      <= o_ps2_d;
      o_pd_q       <= o_pd_d;
      o_pdo_q      <= o_pdo_d;
    end
  end

  // Both RATs reset to the identity map.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_q[i]   <= PW'(i);
        commit_q[i] <= PW'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_q[i]   <= spec_d[i];
        commit_q[i] <= commit_d[i];
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.alloc_en       = alloc_en;
  assign bus.out_valid      = (state_q == S_OUT);
  assign bus.out_inst_valid = o_inst_q;
  assign bus.out_pd_valid   = o_pdv_q;
  assign bus.out_ps1        = o_ps1_q;
  assign bus.out_ps2        = o_ps2_q;
  assign bus.out_pd         = o_pd_q;
  assign bus.out_pd_old     = o_pdo_q;
endmodule
